// File: rtl/serial_sub_sequencer.sv
// Multi-precision subtractor: computes Y = A - B - BorrowIN one nibble per clock
// through a single shared 4-bit subtraction slice, with a start/done handshake.

module subtraction (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       borrowIn,
  output logic [3:0] diff,
  output logic       borrowOut
);
  logic [4:0] full;

  // The fifth bit of the widened difference goes high exactly when the slice underflows
  assign full      = {1'b0, a} - {1'b0, b} - {4'b0000, borrowIn};
  assign diff      = full[3:0];
  assign borrowOut = full[4];
endmodule

module serial_sub_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 BorrowIN,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] Y,
  output logic                 BorrowOut,
  output logic                 overflow
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            state;
  logic [W-1:0]     aReg;
  logic [W-1:0]     bReg;
  logic [W-1:0]     acc;
  logic [W-1:0]     yNew;
  logic [IDXW-1:0]  idx;
  logic             borrowReg;
  logic [3:0]       sliceA;
  logic [3:0]       sliceB;
  logic [3:0]       sliceDiff;
  logic             sliceBorrow;

  assign sliceA = aReg[4*idx +: 4];
  assign sliceB = bReg[4*idx +: 4];

  subtraction u_slice (
    .a         (sliceA),
    .b         (sliceB),
    .borrowIn  (borrowReg),
    .diff      (sliceDiff),
    .borrowOut (sliceBorrow)
  );

  // Accumulator with the current nibble merged in, so the final edge can publish
  // the complete result without waiting an extra cycle.
  always_comb begin
    yNew = acc;
    yNew[4*idx +: 4] = sliceDiff;
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      aReg      <= '0;
      bReg      <= '0;
      acc       <= '0;
      idx       <= '0;
      borrowReg <= 1'b0;
      Y         <= '0;
      BorrowOut <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aReg      <= A;
            bReg      <= B;
            borrowReg <= BorrowIN;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          acc       <= yNew;
          borrowReg <= sliceBorrow;
          idx       <= idx + IDXW'(1);
          // Outputs only change on the final nibble, so partial results are never visible
          if (idx == IDXW'(NIBBLES - 1)) begin
            Y         <= yNew;
            BorrowOut <= sliceBorrow;
            overflow  <= (aReg[W-1] != bReg[W-1]) && (yNew[W-1] != aReg[W-1]);
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_sub_sequencer.sv
// Directed self-checking bench for serial_sub_sequencer with NIBBLES=4:
// per-cycle handshake timing, result values, held start and mid-run reset.

module tb_serial_sub_sequencer;
  localparam int NIB = 4;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BorrowIN;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] Y;
  logic         BorrowOut;
  logic         overflow;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] lastY    = '0;
  logic         lastBo   = 1'b0;
  logic         lastOv   = 1'b0;

  serial_sub_sequencer #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .A         (A),
    .B         (B),
    .BorrowIN  (BorrowIN),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .Y         (Y),
    .BorrowOut (BorrowOut),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single cycle, then drives inverted junk operands
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(negedge clk);
    A        = a;
    B        = b;
    BorrowIN = bin;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    A        = ~a;
    B        = ~b;
    BorrowIN = ~bin;
  endtask

  task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input logic [W-1:0] expY, input logic expBo,
                       input logic expOv, input bit scramble);
    applyStimulus(a, b, bin);
    for (int i = 1; i <= NIB + 2; i++) begin
      @(negedge clk);
      if (scramble && i == 2) begin
        A = 16'hFFFF;
        B = 16'h0000;
      end
      checkOutput({name, "-busy"},  32'(busy),  32'(i <= NIB));
      checkOutput({name, "-done"},  32'(done),  32'(i == NIB + 1));
      checkOutput({name, "-ready"}, 32'(ready), 32'(i == NIB + 2));
      if (i <= NIB) begin
        checkOutput({name, "-Yhold"},  32'(Y),         32'(lastY));
        checkOutput({name, "-BOhold"}, 32'(BorrowOut), 32'(lastBo));
        checkOutput({name, "-OVhold"}, 32'(overflow),  32'(lastOv));
      end else begin
        checkOutput({name, "-Y"},  32'(Y),         32'(expY));
        checkOutput({name, "-BO"}, 32'(BorrowOut), 32'(expBo));
        checkOutput({name, "-OV"}, 32'(overflow),  32'(expOv));
      end
    end
    lastY  = expY;
    lastBo = expBo;
    lastOv = expOv;
  endtask

  logic [W-1:0] opA  [3];
  logic [W-1:0] opB  [3];
  logic [W-1:0] opY  [3];
  logic         opBo [3];

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    A        = '0;
    B        = '0;
    BorrowIN = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst-ready", 32'(ready),     32'd1);
    checkOutput("rst-busy",  32'(busy),      32'd0);
    checkOutput("rst-done",  32'(done),      32'd0);
    checkOutput("rst-Y",     32'(Y),         32'd0);
    checkOutput("rst-BO",    32'(BorrowOut), 32'd0);
    checkOutput("rst-OV",    32'(overflow),  32'd0);
    reset = 1'b0;

    runOp("basic",   16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);
    runOp("under",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    runOp("ovPos",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    runOp("ovNeg",   16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    runOp("binScr",  16'h0005, 16'h0002, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1);
    runOp("binZero", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // start held high: a new operation is accepted every NIB+2 cycles
    opA[0] = 16'h1000; opB[0] = 16'h0001; opY[0] = 16'h0FFF; opBo[0] = 1'b0;
    opA[1] = 16'h0100; opB[1] = 16'h0200; opY[1] = 16'hFF00; opBo[1] = 1'b1;
    opA[2] = 16'hABCD; opB[2] = 16'h1111; opY[2] = 16'h9ABC; opBo[2] = 1'b0;
    @(negedge clk);
    A        = opA[0];
    B        = opB[0];
    BorrowIN = 1'b0;
    start    = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c % 6 == 5) begin
        lastY  = opY[(c - 1) / 6];
        lastBo = opBo[(c - 1) / 6];
      end
      checkOutput("held-done",  32'(done),      32'(c % 6 == 5));
      checkOutput("held-busy",  32'(busy),      32'((c % 6 >= 1) && (c % 6 <= 4)));
      checkOutput("held-Y",     32'(Y),         32'(lastY));
      checkOutput("held-BO",    32'(BorrowOut), 32'(lastBo));
      if (c % 6 == 1) begin
        A = 16'h5A5A;
        B = 16'hA5A5;
      end
      if (c % 6 == 0 && c < 18) begin
        A = opA[c / 6];
        B = opB[c / 6];
      end
      if (c == 18) start = 1'b0;
    end
    lastOv = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("held-idle", 32'(ready), 32'd1);

    // Reset during the second RUN cycle aborts without a done pulse
    applyStimulus(16'h1234, 16'h0235, 1'b0);
    @(negedge clk);
    checkOutput("abort-run1", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort-ready", 32'(ready),     32'd1);
    checkOutput("abort-busy",  32'(busy),      32'd0);
    checkOutput("abort-done",  32'(done),      32'd0);
    checkOutput("abort-Y",     32'(Y),         32'd0);
    checkOutput("abort-BO",    32'(BorrowOut), 32'd0);
    checkOutput("abort-OV",    32'(overflow),  32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort-nodone", 32'(done), 32'd0);
    end
    lastY  = '0;
    lastBo = 1'b0;
    lastOv = 1'b0;
    runOp("afterRst", 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
